// File: rtl/div_pkg.sv
// Shared divider definitions: bus widths, handshake levels, FSM state codes
// and the two's complement helper used for the sign handling.
package div_pkg;

    localparam int REG_BUS        = 32;
    localparam int DOUBLE_REG_BUS = 64;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic [5:0] DIV_ITERS = 6'd32;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    function automatic logic [REG_BUS-1:0] twos_neg(input logic [REG_BUS-1:0] x);
        return ~x + REG_BUS'(1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// Work register layout: [64:33] partial remainder, [31:0] quotient bits shifted in from the LSB.
module div_step
    import div_pkg::*;
(
    input  logic [DOUBLE_REG_BUS:0] work_i,
    input  logic [REG_BUS-1:0]      divisor_i,
    output logic [DOUBLE_REG_BUS:0] work_o
);

    logic              fits;
    logic [REG_BUS-1:0] trial;

    // The shifted remainder can need 33 bits; the difference always fits in 32 when taken.
    always_comb begin
        fits  = work_i[DOUBLE_REG_BUS:REG_BUS] >= {1'b0, divisor_i};
        trial = work_i[DOUBLE_REG_BUS-1:REG_BUS] - divisor_i;
        if (fits) begin
            work_o = {trial, work_i[REG_BUS-1:0], 1'b1};
        end else begin
            work_o = {work_i[DOUBLE_REG_BUS-1:0], 1'b0};
        end
    end

endmodule

// File: rtl/div.sv
// Multi-cycle DIV/DIVU: one quotient bit per clock, result valid 33 edges after start (2 for a zero divisor).
// Result and ready are held while start stays high; dropping start or annul aborts an in-flight divide.
module div
    import div_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      signed_div_i,
    input  logic [REG_BUS-1:0]        opdata1_i,
    input  logic [REG_BUS-1:0]        opdata2_i,
    input  logic                      start_i,
    input  logic                      annul_i,
    output logic [DOUBLE_REG_BUS-1:0] result_o,
    output logic                      ready_o
);

    div_state_e                state_q, state_d;
    logic [5:0]                cnt_q, cnt_d;
    logic [DOUBLE_REG_BUS:0]   work_q, work_d, work_step;
    logic [REG_BUS-1:0]        divisor_q, divisor_d;
    logic                      q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic [DOUBLE_REG_BUS-1:0] result_q, result_d;
    logic                      ready_q, ready_d;
    logic                      op1_neg, op2_neg;
    logic [REG_BUS-1:0]        quot, rem;

    div_step u_step (
        .work_i    (work_q),
        .divisor_i (divisor_q),
        .work_o    (work_step)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        result_d  = result_q;
        ready_d   = ready_q;

        op1_neg = signed_div_i & opdata1_i[REG_BUS-1];
        op2_neg = signed_div_i & opdata2_i[REG_BUS-1];
        quot    = q_neg_q ? twos_neg(work_q[REG_BUS-1:0]) : work_q[REG_BUS-1:0];
        rem     = r_neg_q ? twos_neg(work_q[DOUBLE_REG_BUS:REG_BUS+1])
                          : work_q[DOUBLE_REG_BUS:REG_BUS+1];

        case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d   = DIV_ON;
                        cnt_d     = '0;
                        work_d    = {{REG_BUS{1'b0}},
                                     op1_neg ? twos_neg(opdata1_i) : opdata1_i, 1'b0};
                        divisor_d = op2_neg ? twos_neg(opdata2_i) : opdata2_i;
                        q_neg_d   = op1_neg ^ op2_neg;
                        r_neg_d   = op1_neg;
                    end
                end
            end
            DIV_BY_ZERO: begin
                state_d  = DIV_END;
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
            end
            DIV_ON: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                if (annul_i || start_i == DIV_STOP) begin
                    state_d = DIV_FREE;
                end else if (cnt_q != DIV_ITERS) begin
                    work_d = work_step;
                    cnt_d  = cnt_q + 6'd1;
                end else begin
                    state_d  = DIV_END;
                    cnt_d    = '0;
                    result_d = {rem, quot};
                    ready_d  = DIV_RESULT_READY;
                end
            end
            DIV_END: begin
                // annul is deliberately ignored here; only start releases the result.
                if (start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end else begin
                    ready_d = DIV_RESULT_READY;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
